// File: rtl/sha256_chunk_packer.sv
// sha256_chunk_packer
// Packs a stream of W-bit message words (MSB first) into SHA-256 padded
// 512-bit chunks: message bits, a single '1' bit, zeros, and a 64-bit
// big-endian bit length in the last 64 bits of the final chunk.
// Optional feature: `define SHA256_PACKER_NONCE_EN adds a nonce_in port whose
// value (sampled at start) overwrites message bits [NONCE_OFS +: 32].
module sha256_chunk_packer #(
    parameter int W         = 32,
    parameter int LEN_W     = 32,
    parameter int IDX_W     = 16,
    parameter int NONCE_OFS = 608
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len_bits,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             chunk_valid,
    input  logic             chunk_ready,
    output logic [511:0]     chunk,
    output logic [IDX_W-1:0] chunk_idx,
    output logic             chunk_last,
    output logic             busy,
    output logic             done
`ifdef SHA256_PACKER_NONCE_EN
    ,
    input  logic [31:0]      nonce_in
`endif
);

    localparam int         WSH         = $clog2(W);
    localparam logic [9:0] W_P         = 10'(W);
    localparam logic [9:0] PTR_FULL    = 10'd512;
    localparam logic [9:0] PTR_LEN_MAX = 10'd447;

    // Elaboration-time guard on the legal configuration space.
    if ((W != 8 && W != 32 && W != 64) || (NONCE_OFS % 32) != 0) begin : g_bad_cfg
        $error("sha256_chunk_packer: W must be 8/32/64 and NONCE_OFS a multiple of 32");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PAD,
        S_LEN,
        S_EMIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [511:0]       buf_q;
    logic [9:0]         ptr_q;          // next free message bit within the chunk, 0..512
    logic [LEN_W-1:0]   words_left_q;
    logic [LEN_W-1:0]   len_q;
    logic [IDX_W-1:0]   idx_q;
    logic               last_q;
    logic               len_pend_q;     // an extra length-only chunk follows this one
    logic               pad_carry_q;    // the '1' pad bit did not fit and moves to the length chunk

    logic [LEN_W-1:0]   start_words;
    logic [63:0]        len64;
    logic [W-1:0]       wr_word;
    logic [511:0]       padded;

    assign start_words = msg_len_bits >> WSH;
    assign len64       = 64'(len_q);
    // A ptr of 512 shifts the pad bit completely out, leaving the buffer untouched.
    assign padded      = buf_q | ({1'b1, 511'b0} >> ptr_q);

`ifdef SHA256_PACKER_NONCE_EN
    logic [31:0]      nonce_q;
    logic [LEN_W-1:0] bits_done_q;      // message bit offset of the word being written

    // Replace any bit of the word that lands inside the 32-bit nonce slot.
    function automatic logic [W-1:0] inject_nonce(input logic [W-1:0]     word,
                                                  input logic [LEN_W-1:0] base,
                                                  input logic [31:0]      nonce);
        logic [W-1:0] res;
        longint       pos;
        logic [4:0]   nb;
        res = word;
        for (int i = 0; i < W; i++) begin
            pos = longint'(base) + longint'(W - 1 - i);
            if (pos >= longint'(NONCE_OFS) && pos < longint'(NONCE_OFS) + 64'sd32) begin
                nb     = 5'(64'sd31 - (pos - longint'(NONCE_OFS)));
                res[i] = nonce[nb];
            end
        end
        return res;
    endfunction

    assign wr_word = inject_nonce(in_data, bits_done_q, nonce_q);
`else
    assign wr_word = in_data;
`endif

    assign chunk      = buf_q;
    assign chunk_idx  = idx_q;
    assign chunk_last = last_q;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        chunk_valid = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = start;
                if (start) state_d = (start_words == '0) ? S_PAD : S_FILL;
            end
            S_FILL: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    // End of message wins over a full buffer so padding sees the final ptr.
                    if (words_left_q == LEN_W'(1))      state_d = S_PAD;
                    else if (ptr_q + W_P == PTR_FULL)   state_d = S_EMIT;
                end
            end
            S_PAD: begin
                busy    = 1'b1;
                state_d = S_EMIT;
            end
            S_LEN: begin
                busy    = 1'b1;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                busy        = 1'b1;
                chunk_valid = 1'b1;
                if (chunk_ready) begin
                    if (last_q)          state_d = S_DONE;
                    else if (len_pend_q) state_d = S_LEN;
                    else                 state_d = S_FILL;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Chunk buffer, pointers and per-message bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_q        <= '0;
            ptr_q        <= '0;
            words_left_q <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            last_q       <= 1'b0;
            len_pend_q   <= 1'b0;
            pad_carry_q  <= 1'b0;
`ifdef SHA256_PACKER_NONCE_EN
            nonce_q      <= '0;
            bits_done_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_q        <= msg_len_bits;
                        words_left_q <= start_words;
                        ptr_q        <= '0;
                        idx_q        <= '0;
                        last_q       <= 1'b0;
                        len_pend_q   <= 1'b0;
                        pad_carry_q  <= 1'b0;
                        buf_q        <= '0;
`ifdef SHA256_PACKER_NONCE_EN
                        nonce_q      <= nonce_in;
                        bits_done_q  <= '0;
`endif
                    end
                end
                S_FILL: begin
                    if (in_valid) begin
                        // Buffer below ptr is already zero, so OR-ing places the word.
                        buf_q        <= buf_q | ({wr_word, {(512-W){1'b0}}} >> ptr_q);
                        ptr_q        <= ptr_q + W_P;
                        words_left_q <= words_left_q - LEN_W'(1);
`ifdef SHA256_PACKER_NONCE_EN
                        bits_done_q  <= bits_done_q + LEN_W'(W);
`endif
                    end
                end
                S_PAD: begin
                    if (ptr_q <= PTR_LEN_MAX) begin
                        buf_q  <= {padded[511:64], len64};
                        last_q <= 1'b1;
                    end else begin
                        buf_q       <= padded;
                        len_pend_q  <= 1'b1;
                        pad_carry_q <= (ptr_q == PTR_FULL);
                    end
                end
                S_LEN: begin
                    buf_q       <= {pad_carry_q, 447'b0, len64};
                    last_q      <= 1'b1;
                    len_pend_q  <= 1'b0;
                    pad_carry_q <= 1'b0;
                end
                S_EMIT: begin
                    if (chunk_ready) begin
                        buf_q  <= '0;
                        ptr_q  <= '0;
                        idx_q  <= idx_q + IDX_W'(1);
                        last_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_chunk_packer.sv
// Self-checking bench for sha256_chunk_packer: three instances (W = 8, 32, 64)
// share stimulus through a select; expected chunks come from a byte-level
// SHA-256 padding model. Define SHA256_PACKER_NONCE_EN to exercise the nonce slot.
module tb_sha256_chunk_packer;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         in_valid;
    logic         chunk_ready;
    logic [1:0]   sel;
    logic [31:0]  msg_len;
    logic [63:0]  in_data;

    logic [2:0]   start_v, in_valid_v, ready_v;
    logic [2:0]   in_ready_v, chunk_valid_v, last_v, busy_v, done_v;
    logic [511:0] chunk_v [3];
    logic [15:0]  idx_v [3];

    logic         in_ready_m, chunk_valid_m, last_m, busy_m, done_m;
    logic [511:0] chunk_m;
    logic [15:0]  idx_m;

`ifdef SHA256_PACKER_NONCE_EN
    logic [31:0]  nonce = 32'hDEADBEEF;
`endif

    byte unsigned msg[$];
    logic [511:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;

    always #5 clock = ~clock;

    for (genvar k = 0; k < 3; k++) begin : g_fan
        assign start_v[k]    = start       && (sel == 2'(k));
        assign in_valid_v[k] = in_valid    && (sel == 2'(k));
        assign ready_v[k]    = chunk_ready && (sel == 2'(k));
    end

    assign in_ready_m    = in_ready_v[sel];
    assign chunk_valid_m = chunk_valid_v[sel];
    assign last_m        = last_v[sel];
    assign busy_m        = busy_v[sel];
    assign done_m        = done_v[sel];
    assign chunk_m       = chunk_v[sel];
    assign idx_m         = idx_v[sel];

    sha256_chunk_packer #(.W(8)) u_w8 (
        .clock(clock), .reset(reset), .start(start_v[0]), .msg_len_bits(msg_len),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .in_data(in_data[7:0]),
        .chunk_valid(chunk_valid_v[0]), .chunk_ready(ready_v[0]), .chunk(chunk_v[0]),
        .chunk_idx(idx_v[0]), .chunk_last(last_v[0]), .busy(busy_v[0]), .done(done_v[0])
`ifdef SHA256_PACKER_NONCE_EN
        , .nonce_in(nonce)
`endif
    );

    sha256_chunk_packer #(.W(32)) u_w32 (
        .clock(clock), .reset(reset), .start(start_v[1]), .msg_len_bits(msg_len),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .in_data(in_data[31:0]),
        .chunk_valid(chunk_valid_v[1]), .chunk_ready(ready_v[1]), .chunk(chunk_v[1]),
        .chunk_idx(idx_v[1]), .chunk_last(last_v[1]), .busy(busy_v[1]), .done(done_v[1])
`ifdef SHA256_PACKER_NONCE_EN
        , .nonce_in(nonce)
`endif
    );

    sha256_chunk_packer #(.W(64)) u_w64 (
        .clock(clock), .reset(reset), .start(start_v[2]), .msg_len_bits(msg_len),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]), .in_data(in_data),
        .chunk_valid(chunk_valid_v[2]), .chunk_ready(ready_v[2]), .chunk(chunk_v[2]),
        .chunk_idx(idx_v[2]), .chunk_last(last_v[2]), .busy(busy_v[2]), .done(done_v[2])
`ifdef SHA256_PACKER_NONCE_EN
        , .nonce_in(nonce)
`endif
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: standard SHA-256 padding on the byte string, then split into 64-byte blocks.
    function automatic void build_expected(input int len_bits);
        byte unsigned pm[$];
        logic [63:0]  l64;
        logic [511:0] c;
        pm = msg;
`ifdef SHA256_PACKER_NONCE_EN
        for (int k = 0; k < 4; k++)
            if (76 + k < pm.size()) pm[76 + k] = 8'(nonce >> (24 - 8 * k));
`endif
        pm.push_back(8'h80);
        while (pm.size() % 64 != 56) pm.push_back(8'h00);
        l64 = 64'(len_bits);
        for (int k = 0; k < 8; k++) pm.push_back(8'(l64 >> (56 - 8 * k)));
        exp_q.delete();
        for (int ch = 0; ch < pm.size() / 64; ch++) begin
            c = '0;
            for (int b = 0; b < 64; b++) c = (c << 8) | 512'(pm[ch * 64 + b]);
            exp_q.push_back(c);
        end
    endfunction

    function automatic logic [63:0] word_at(input int j, input int wbytes);
        logic [63:0] d;
        d = '0;
        for (int b = 0; b < wbytes; b++) d = (d << 8) | 64'(msg[j * wbytes + b]);
        return d;
    endfunction

    // Runs one message through the selected instance; called and returns at a negedge.
    task automatic run_msg(input logic [1:0] wsel, input int stall, input bit rnd);
        int wbytes, nwords, nch, word_i, ci, cyc, stall_cnt;
        int exp_v_cyc, exp_z_cyc, last_hs_cyc;
        bit acc, hs, finished;
        wbytes = (wsel == 2'd0) ? 1 : (wsel == 2'd1) ? 4 : 8;
        nwords = msg.size() / wbytes;
        build_expected(msg.size() * 8);
        nch    = exp_q.size();
        sel    = wsel;
        msg_len = 32'(msg.size() * 8);
        start  = 1'b1;
        #1;
        chk("busy_at_start", busy_m, 1'b1);
        chk("idle_in_ready", in_ready_m, 1'b0);
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        if (nwords > 0) chk("first_in_ready", in_ready_m, 1'b1);
        word_i = 0; ci = 0; cyc = 0; stall_cnt = 0;
        exp_v_cyc = -10; exp_z_cyc = -10; last_hs_cyc = -10; finished = 1'b0;
        while (!finished && cyc < 4000) begin
            if (word_i < nwords) begin
                in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_data  = word_at(word_i, wbytes);
            end else begin
                in_valid = 1'b0;
            end
            chunk_ready = rnd ? ($urandom_range(0, 2) != 0) : (stall_cnt >= stall);
            #1;
            if (cyc == exp_v_cyc) chk("valid_latency", chunk_valid_m, 1'b1);
            if (cyc == exp_z_cyc) chk("pad_cycle", chunk_valid_m, 1'b0);
            if (word_i >= nwords) chk("in_ready_after_msg", in_ready_m, 1'b0);
            chk("done_pulse", done_m, (cyc == last_hs_cyc + 1));
            if (chunk_valid_m) begin
                chk("in_ready_in_emit", in_ready_m, 1'b0);
                if (ci < nch) begin
                    chk("chunk_data", chunk_m, exp_q[ci]);
                    chk("chunk_idx", idx_m, 512'(ci));
                    chk("chunk_last", last_m, (ci == nch - 1));
                end else begin
                    checks++;
                    errors++;
                    $error("FAIL extra_chunk observed=%0d expected=%0d", ci + 1, nch);
                end
                stall_cnt++;
            end
            if (cyc == last_hs_cyc + 1) begin
                chk("busy_at_done", busy_m, 1'b0);
                finished = 1'b1;
            end
            acc = in_valid && in_ready_m;
            hs  = chunk_valid_m && chunk_ready;
            @(posedge clock);
            if (acc) begin
                if (word_i == nwords - 1) begin
                    exp_z_cyc = cyc + 1;
                    exp_v_cyc = cyc + 2;
                end else if (((word_i + 1) * wbytes) % 64 == 0) begin
                    exp_v_cyc = cyc + 1;
                end
                word_i++;
            end
            if (hs) begin
                ci++;
                stall_cnt = 0;
                if (ci == nch) last_hs_cyc = cyc;
            end
            @(negedge clock);
            cyc++;
        end
        in_valid    = 1'b0;
        chunk_ready = 1'b0;
        if (!finished) begin
            checks++;
            errors++;
            $error("FAIL timeout observed=%0d chunks expected=%0d", ci, nch);
        end
        @(negedge clock);
        chk("done_cleared", done_m, 1'b0);
        chk("chunks_seen", 512'(ci), 512'(nch));
    endtask

    task automatic load_abc();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
    endtask

    task automatic load_random(input int nbytes);
        msg.delete();
        for (int i = 0; i < nbytes; i++) msg.push_back(8'($urandom));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; chunk_ready = 1'b0;
        sel = 2'd0; msg_len = '0; in_data = '0;
        repeat (3) @(negedge clock);
        chk("rst_chunk_valid", chunk_valid_m, 1'b0);
        chk("rst_chunk", chunk_m, '0);
        chk("rst_busy", busy_m, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        // "abc" on W=8
        load_abc();
        run_msg(2'd0, 0, 1'b0);
        // 448-bit message on W=32: pad bit spills the length into a second chunk
        load_random(56);
        run_msg(2'd1, 0, 1'b0);
        // empty message
        msg.delete();
        run_msg(2'd1, 0, 1'b0);
        // 1024 bits on W=64 with 20-cycle stalls per chunk
        load_random(128);
        run_msg(2'd2, 20, 1'b0);
        // boundary lengths: 440 bits fits, 512 bits moves the pad bit to the length chunk
        load_random(55);
        run_msg(2'd0, 0, 1'b0);
        load_random(64);
        run_msg(2'd0, 2, 1'b0);

        // reset in the middle of FILL, then the "abc" case again
        load_random(10);
        sel = 2'd0; msg_len = 32'd80; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(msg[i]);
            @(posedge clock);
            @(negedge clock);
        end
        in_valid = 1'b0;
        chk("mid_fill_in_ready", in_ready_m, 1'b1);
        reset = 1'b1;
        #1;
        chk("mr_in_ready", in_ready_m, 1'b0);
        chk("mr_chunk", chunk_m, '0);
        chk("mr_chunk_valid", chunk_valid_m, 1'b0);
        chk("mr_idx", idx_m, '0);
        chk("mr_last", last_m, 1'b0);
        chk("mr_busy", busy_m, 1'b0);
        chk("mr_done", done_m, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        load_abc();
        run_msg(2'd0, 0, 1'b0);

`ifdef SHA256_PACKER_NONCE_EN
        // 640-bit message on W=32: message bits 608..639 become the nonce
        load_random(80);
        run_msg(2'd1, 0, 1'b0);
`endif

        // randomized lengths, input gaps and output backpressure on every width
        for (int t = 0; t < 9; t++) begin
            logic [1:0] ws;
            int         wb;
            ws = 2'(t % 3);
            wb = (ws == 2'd0) ? 1 : (ws == 2'd1) ? 4 : 8;
            load_random(wb * int'($urandom_range(0, 150 / wb)));
            run_msg(ws, 0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
